// File: rtl/layer2_window_feeder.sv
// layer2_window_feeder: second-layer input feeder.
// Preloads the first WIN-word window plus one prefetch word from feature
// memory, then slides the window by one word per Compute_Enable cycle.
// Optional feature: define FEEDER_STALL_CNT_EN to add the stall_cnt output.
module layer2_window_feeder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int IN_LEN = 16,
  parameter int WIN    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Linear_Start,
  input  logic                    Compute_Start,
  input  logic                    Compute_Enable,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_data,
  output logic [WIN*DATA_W-1:0]   win_data,
  output logic                    win_valid,
  output logic                    Done_Init,
  output logic                    Done_Full
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int CW   = ADDR_W + 1;
  localparam int NPOS = IN_LEN - WIN + 1;

  // Preload fetches the first window plus one prefetch word, if one exists.
  localparam logic [CW-1:0] P_WORDS    = (IN_LEN == WIN) ? CW'(WIN) : CW'(WIN + 1);
  localparam logic [CW-1:0] WIN_C      = CW'(WIN);
  localparam logic [CW-1:0] LEN_C      = CW'(IN_LEN);
  localparam logic [CW-1:0] LAST_POS   = CW'(NPOS - 1);
  localparam logic [CW-1:0] STRM_ADDR0 = CW'(WIN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_READY,
    S_STREAM,
    S_FULL
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           addr_q, addr_d;
  logic [CW-1:0]           cap_q, cap_d;
  logic [CW-1:0]           pos_q, pos_d;
  logic                    rd_d_q, rd_d_d;
  logic [DATA_W-1:0]       nxt_q, nxt_d;
  logic [WIN*DATA_W-1:0]   win_q, win_d;
  logic                    win_valid_q, win_valid_d;
  logic                    done_init_q, done_init_d;
  logic                    done_full_q, done_full_d;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]             stall_q, stall_d;
`endif

  logic                    consume;
  logic [DATA_W-1:0]       src;

  // Read strobe is combinational on consume so that the requested word
  // arrives exactly when the following consume needs it (zero bubbles).
  always_comb begin
    consume  = Compute_Enable & win_valid_q;
    mem_rd   = ((state_q == S_PRELOAD) && (addr_q < P_WORDS)) ||
               (consume && (addr_q < LEN_C));
    mem_addr = mem_rd ? addr_q[ADDR_W-1:0] : '0;
    src      = rd_d_q ? mem_data : nxt_q;
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cap_d       = cap_q;
    pos_d       = pos_q;
    rd_d_d      = mem_rd;
    nxt_d       = nxt_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    done_init_d = done_init_q;
    done_full_d = done_full_q;
`ifdef FEEDER_STALL_CNT_EN
    stall_d     = stall_q;
`endif

    case (state_q)
      S_IDLE, S_FULL: begin
        if (Linear_Start) begin
          state_d     = S_PRELOAD;
          addr_d      = '0;
          cap_d       = '0;
          pos_d       = '0;
          done_full_d = 1'b0;
`ifdef FEEDER_STALL_CNT_EN
          stall_d     = '0;
`endif
        end
      end

      S_PRELOAD: begin
        if (mem_rd) begin
          addr_d = addr_q + 1'b1;
        end
        if (rd_d_q) begin
          if (cap_q < WIN_C) begin
            win_d = {mem_data, win_q[WIN*DATA_W-1:DATA_W]};
          end else begin
            nxt_d = mem_data;
          end
          cap_d = cap_q + 1'b1;
          if (cap_q == P_WORDS - 1'b1) begin
            state_d     = S_READY;
            done_init_d = 1'b1;
          end
        end
      end

      S_READY: begin
        if (Compute_Start) begin
          state_d     = S_STREAM;
          done_init_d = 1'b0;
          win_valid_d = 1'b1;
          pos_d       = '0;
          addr_d      = STRM_ADDR0;
        end
      end

      S_STREAM: begin
        if (consume) begin
          if (mem_rd) begin
            addr_d = addr_q + 1'b1;
          end
          if (pos_q == LAST_POS) begin
            state_d     = S_FULL;
            win_valid_d = 1'b0;
            done_full_d = 1'b1;
          end else begin
            win_d = {src, win_q[WIN*DATA_W-1:DATA_W]};
            pos_d = pos_q + 1'b1;
          end
        end else if (rd_d_q) begin
          // Park the in-flight word while frozen so it is not lost.
          nxt_d = mem_data;
        end
`ifdef FEEDER_STALL_CNT_EN
        if (!Compute_Enable && (stall_q != '1)) begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cap_q       <= '0;
      pos_q       <= '0;
      rd_d_q      <= 1'b0;
      nxt_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      done_init_q <= 1'b0;
      done_full_q <= 1'b0;
`ifdef FEEDER_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cap_q       <= cap_d;
      pos_q       <= pos_d;
      rd_d_q      <= rd_d_d;
      nxt_q       <= nxt_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      done_init_q <= done_init_d;
      done_full_q <= done_full_d;
`ifdef FEEDER_STALL_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign win_data  = win_q;
  assign win_valid = win_valid_q;
  assign Done_Init = done_init_q;
  assign Done_Full = done_full_q;
`ifdef FEEDER_STALL_CNT_EN
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_layer2_window_feeder.sv
// Testbench for layer2_window_feeder: table-driven preload sequence,
// hand-written reset / small-vector cases, and randomized streaming
// against a window-index reference model.
module tb_layer2_window_feeder;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int LEN = 16;
  localparam int W   = 4;
  localparam int NP  = LEN - W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, ls, cs, ce;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic [W*DW-1:0]   win_data;
  logic              win_valid, done_init, done_full;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  logic              ls4, cs4, ce4;
  logic              mem_rd4;
  logic [AW-1:0]     mem_addr4;
  logic [DW-1:0]     mem_data4;
  logic [W*DW-1:0]   win_data4;
  logic              win_valid4, done_init4, done_full4;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt4;
`endif

  layer2_window_feeder #(.DATA_W(DW), .ADDR_W(AW), .IN_LEN(LEN), .WIN(W)) dut (
    .clk(clk), .rst(rst), .Linear_Start(ls), .Compute_Start(cs), .Compute_Enable(ce),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .win_data(win_data), .win_valid(win_valid), .Done_Init(done_init), .Done_Full(done_full)
`ifdef FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  layer2_window_feeder #(.DATA_W(DW), .ADDR_W(AW), .IN_LEN(W), .WIN(W)) dut4 (
    .clk(clk), .rst(rst), .Linear_Start(ls4), .Compute_Start(cs4), .Compute_Enable(ce4),
    .mem_rd(mem_rd4), .mem_addr(mem_addr4), .mem_data(mem_data4),
    .win_data(win_data4), .win_valid(win_valid4), .Done_Init(done_init4), .Done_Full(done_full4)
`ifdef FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt4)
`endif
  );

  // Feature memories: data valid one cycle after the read strobe.
  logic [DW-1:0] mem [LEN];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_rd4) mem_data4 <= mem_addr4 + 8'd1;

  int tests = 0;
  int fails = 0;
  int nrd, maxa, viol, nrd4, maxa4, viol4;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observe read bus mid-cycle, then advance to just after the next edge.
  task automatic tick();
    @(negedge clk);
    if (mem_rd) begin
      nrd++;
      if (int'(mem_addr) > maxa) maxa = int'(mem_addr);
      if (int'(mem_addr) >= LEN) viol++;
    end else if (mem_addr != '0) viol++;
    if (mem_rd4) begin
      nrd4++;
      if (int'(mem_addr4) > maxa4) maxa4 = int'(mem_addr4);
      if (int'(mem_addr4) >= W) viol4++;
    end else if (mem_addr4 != '0) viol4++;
    @(posedge clk);
    #1;
  endtask

  // Reference window k = words k..k+W-1, word 0 in LSBs.
  function automatic logic [W*DW-1:0] exp_win(input int k);
    logic [W*DW-1:0] w;
    for (int i = 0; i < W; i++) w[i*DW +: DW] = mem[k + i];
    return w;
  endfunction

  typedef struct {
    logic        ls, cs, ce;
    logic        rd;
    logic [7:0]  addr;
    logic        init, valid, full;
    logic [31:0] win;
  } vec_t;

  vec_t tbl[11];

  // Preload + stream from READY/FULL; mode 0 continuous, 1 three-cycle
  // stall at window 4, 2 random enable with Linear_Start noise.
  task automatic run_scenario(input int mode);
    int pos, stalls, cyc;
    logic cev;
    nrd = 0; maxa = 0; viol = 0;
    ls = 1'b1; cs = 1'b0; ce = 1'b0;
    tick();
    ls = 1'b0;
    chk("pre_rd0", mem_rd, 1'b1);
    chk("pre_addr0", mem_addr, 8'd0);
    chk("pre_full_clr", done_full, 1'b0);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_clr", stall_cnt, 16'd0);
`endif
    cyc = 0;
    while (!done_init && cyc < 20) begin tick(); cyc++; end
    chk("init_seen", done_init, 1'b1);
    chk("init_win", win_data, exp_win(0));
    chk("ready_valid", win_valid, 1'b0);

    cs = 1'b1;
    ce = (mode == 0) ? 1'b1 : ((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    tick();
    cs = 1'b0;
    chk("strm_init_drop", done_init, 1'b0);
    pos = 0; stalls = 0; cyc = 0;
    while (pos < NP && cyc < 200) begin
      chk("strm_valid", win_valid, 1'b1);
      chk("strm_win", win_data, exp_win(pos));
      chk("strm_full", done_full, 1'b0);
      case (mode)
        0:       cev = 1'b1;
        1:       cev = !(pos == 4 && stalls < 3);
        default: cev = ($urandom_range(0, 2) != 0);
      endcase
      ce = cev;
      if (mode == 2) ls = 1'($urandom_range(0, 1));
      #1;
      chk("strm_rd", mem_rd, cev && (W + 1 + pos < LEN));
      chk("strm_addr", mem_addr, (cev && (W + 1 + pos < LEN)) ? 8'(W + 1 + pos) : 8'd0);
      tick();
      if (cev) pos++; else stalls++;
      cyc++;
    end
    ls = 1'b0; ce = 1'b0;
    chk("strm_bound", pos, NP);
    chk("full_set", done_full, 1'b1);
    chk("full_valid", win_valid, 1'b0);
    chk("full_win", win_data, exp_win(NP - 1));
    chk("reads_total", nrd, LEN);
    chk("max_addr", maxa, LEN - 1);
    chk("addr_rules", viol, 0);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
    if (mode == 1) chk("stall_three", stall_cnt, 16'd3);
`endif
    tick(); tick();
    chk("full_hold", done_full, 1'b1);
    chk("full_win_hold", win_data, exp_win(NP - 1));
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_hold", stall_cnt, stalls);
`endif
  endtask

  initial begin
    for (int i = 0; i < LEN; i++) mem[i] = 8'(i + 1);
    //            ls    cs    ce    rd    addr   init  valid full  win
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 32'h00000000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 32'h01000000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 32'h02010000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 32'h03020100};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h04030201};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h04030201};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 32'h04030201};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 32'h04030201};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b1, 1'b0, 32'h05040302};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 32'h06050403};

    rst = 1'b0; ls = 1'b0; cs = 1'b0; ce = 1'b0;
    ls4 = 1'b0; cs4 = 1'b0; ce4 = 1'b0;
    nrd = 0; maxa = 0; viol = 0; nrd4 = 0; maxa4 = 0; viol4 = 0;
    tick(); tick();
    chk("rst_valid", win_valid, 1'b0);
    chk("rst_init", done_init, 1'b0);
    chk("rst_full", done_full, 1'b0);
    chk("rst_win", win_data, 32'h0);
    rst = 1'b1;

    // Preload timing and first stream steps.
    for (int v = 0; v < 11; v++) begin
      ls = tbl[v].ls; cs = tbl[v].cs; ce = tbl[v].ce;
      tick();
      chk($sformatf("tbl%0d_rd", v), mem_rd, tbl[v].rd);
      chk($sformatf("tbl%0d_addr", v), mem_addr, tbl[v].addr);
      chk($sformatf("tbl%0d_init", v), done_init, tbl[v].init);
      chk($sformatf("tbl%0d_valid", v), win_valid, tbl[v].valid);
      chk($sformatf("tbl%0d_full", v), done_full, tbl[v].full);
      chk($sformatf("tbl%0d_win", v), win_data, tbl[v].win);
    end

    // Two-cycle reset in the middle of streaming.
    rst = 1'b0; ls = 1'b0; cs = 1'b0; ce = 1'b1;
    tick(); tick();
    chk("mid_rst_rd", mem_rd, 1'b0);
    chk("mid_rst_addr", mem_addr, 8'd0);
    chk("mid_rst_win", win_data, 32'h0);
    chk("mid_rst_valid", win_valid, 1'b0);
    chk("mid_rst_init", done_init, 1'b0);
    chk("mid_rst_full", done_full, 1'b0);
`ifdef FEEDER_STALL_CNT_EN
    chk("mid_rst_stall", stall_cnt, 16'd0);
`endif
    rst = 1'b1; ce = 1'b0; cs = 1'b1;
    tick();
    cs = 1'b0;
    tick(); tick();
    chk("idle_cs_ignored", win_valid, 1'b0);
    chk("idle_cs_init", done_init, 1'b0);
    chk("idle_cs_rd", mem_rd, 1'b0);

    run_scenario(0);
    run_scenario(1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
      run_scenario(2);
    end

    // Degenerate vector: IN_LEN == WIN.
    nrd4 = 0; maxa4 = 0; viol4 = 0;
    ls4 = 1'b1;
    tick();
    ls4 = 1'b0;
    for (int c = 0; c < 20 && !done_init4; c++) tick();
    chk("n4_init", done_init4, 1'b1);
    chk("n4_reads", nrd4, W);
    chk("n4_maxa", maxa4, W - 1);
    chk("n4_win", win_data4, 32'h04030201);
    cs4 = 1'b1;
    tick();
    cs4 = 1'b0;
    chk("n4_valid", win_valid4, 1'b1);
    chk("n4_nofull", done_full4, 1'b0);
    ce4 = 1'b1;
    #1;
    chk("n4_no_extra_rd", mem_rd4, 1'b0);
    tick();
    ce4 = 1'b0;
    chk("n4_full", done_full4, 1'b1);
    chk("n4_valid_drop", win_valid4, 1'b0);
    chk("n4_win_hold", win_data4, 32'h04030201);
    chk("n4_addr_rules", viol4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
